// File: rtl/ltsm_pkg.sv
// Shared MBTRAIN REPAIR definitions: sideband message codes and sequencer states,
// used by both the TX and RX repair sequencers.
package ltsm_pkg;

  localparam logic [3:0] SB_NONE     = 4'd0;
  localparam logic [3:0] SB_INIT_REQ = 4'd1;
  localparam logic [3:0] SB_INIT_RSP = 4'd2;
  localparam logic [3:0] SB_DEG_REQ  = 4'd3;
  localparam logic [3:0] SB_DEG_RSP  = 4'd4;
  localparam logic [3:0] SB_END_REQ  = 4'd5;
  localparam logic [3:0] SB_END_RSP  = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_DEGRADE = 3'd2,
    ST_END     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } repair_state_e;

  // Response that advances the sequence out of a request state.
  function automatic logic [3:0] expected_rsp(input repair_state_e st);
    case (st)
      ST_INIT:    return SB_INIT_RSP;
      ST_DEGRADE: return SB_DEG_RSP;
      ST_END:     return SB_END_RSP;
      default:    return SB_NONE;
    endcase
  endfunction

  function automatic logic is_request_state(input repair_state_e st);
    case (st)
      ST_INIT, ST_DEGRADE, ST_END: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/repair_timeout_cnt.sv
// Per-state response timer: synchronous clear, count enable, expiry flag on the last cycle.
module repair_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 8000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;

  // Clear has priority so a freshly entered state always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/repair_tx_gen.sv
// MBTRAIN REPAIR TX sequencer: issues INIT / DEGRADE / END requests, reports the
// functional-group mask, and exits on timeout or when no lane group is usable.
module repair_tx_gen
  import ltsm_pkg::*;
#(
  parameter int unsigned NUM_GROUPS  = 2,
  parameter int unsigned ENC_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 8000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [3:0]            i_sideband_message,
  input  logic                  i_rx_msg_valid,
  input  logic                  i_busy_negedge_detected,
  input  logic                  i_valid_rx,
  input  logic [NUM_GROUPS-1:0] i_group_functional,
  output logic [3:0]            o_sideband_message,
  output logic                  o_valid_tx,
  output logic [ENC_W-1:0]      o_sideband_data_lanes_encoding,
  output logic                  o_test_ack,
  output logic                  o_error,
  output logic                  o_timeout
);

  repair_state_e    state_r, state_s;
  logic [3:0]       msg_r, msg_s;
  logic [ENC_W-1:0] enc_r, enc_s;
  logic             ack_r, ack_s;
  logic             err_r, err_s;
  logic             tmo_r, tmo_s;
  logic             vtx_r;
  logic             set_vtx_s, kill_vtx_s;
  logic             resp_hit_s;
  logic             expire_s;
  logic             cnt_en_s, cnt_clr_s;

  assign resp_hit_s = i_rx_msg_valid && (i_sideband_message == expected_rsp(state_r));
  assign cnt_en_s   = is_request_state(state_r);
  assign cnt_clr_s  = (state_s != state_r);

  repair_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .expire (expire_s)
  );

  // Next state and next output values; abort on i_en low outranks everything.
  always_comb begin
    state_s    = state_r;
    msg_s      = msg_r;
    enc_s      = enc_r;
    ack_s      = ack_r;
    err_s      = err_r;
    tmo_s      = tmo_r;
    set_vtx_s  = 1'b0;
    kill_vtx_s = 1'b0;
    if ((state_r != ST_IDLE) && !i_en) begin
      state_s    = ST_IDLE;
      msg_s      = SB_NONE;
      enc_s      = '0;
      ack_s      = 1'b0;
      err_s      = 1'b0;
      tmo_s      = 1'b0;
      kill_vtx_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          enc_s = '0;
          ack_s = 1'b0;
          err_s = 1'b0;
          tmo_s = 1'b0;
          if (i_en) begin
            state_s   = ST_INIT;
            msg_s     = SB_INIT_REQ;
            set_vtx_s = 1'b1;
          end else begin
            msg_s      = SB_NONE;
            kill_vtx_s = 1'b1;
          end
        end
        ST_INIT, ST_DEGRADE, ST_END: begin
          if (resp_hit_s) begin
            case (state_r)
              ST_INIT: begin
                if (|i_group_functional) begin
                  state_s   = ST_DEGRADE;
                  msg_s     = SB_DEG_REQ;
                  enc_s     = ENC_W'(i_group_functional);
                  set_vtx_s = 1'b1;
                end else begin
                  state_s    = ST_ERROR;
                  msg_s      = SB_NONE;
                  err_s      = 1'b1;
                  tmo_s      = 1'b0;
                  kill_vtx_s = 1'b1;
                end
              end
              ST_DEGRADE: begin
                state_s   = ST_END;
                msg_s     = SB_END_REQ;
                set_vtx_s = 1'b1;
              end
              default: begin
                state_s    = ST_DONE;
                msg_s      = SB_NONE;
                ack_s      = 1'b1;
                kill_vtx_s = 1'b1;
              end
            endcase
          end else if (expire_s) begin
            state_s    = ST_ERROR;
            msg_s      = SB_NONE;
            err_s      = 1'b1;
            tmo_s      = 1'b1;
            kill_vtx_s = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        ST_DONE, ST_ERROR: begin
          state_s = state_r;
        end
        default: begin
          state_s    = ST_IDLE;
          msg_s      = SB_NONE;
          enc_s      = '0;
          ack_s      = 1'b0;
          err_s      = 1'b0;
          tmo_s      = 1'b0;
          kill_vtx_s = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      msg_r   <= SB_NONE;
      enc_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      msg_r   <= msg_s;
      enc_r   <= enc_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      tmo_r   <= tmo_s;
    end
  end

  // TX request handshake: a new request beats a same-cycle completion of the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vtx_r <= 1'b0;
    end else if (kill_vtx_s) begin
      vtx_r <= 1'b0;
    end else if (set_vtx_s) begin
      vtx_r <= 1'b1;
    end else if (i_busy_negedge_detected && !i_valid_rx) begin
      vtx_r <= 1'b0;
    end else begin
      vtx_r <= vtx_r;
    end
  end

  assign o_sideband_message             = msg_r;
  assign o_valid_tx                     = vtx_r;
  assign o_sideband_data_lanes_encoding = enc_r;
  assign o_test_ack                     = ack_r;
  assign o_error                        = err_r;
  assign o_timeout                      = tmo_r;

endmodule

// File: tb/tb_repair_tx_gen.sv
// Self-checking bench for repair_tx_gen: directed scenarios plus random traffic
// compared against a request-index reference model.
module tb_repair_tx_gen;

  localparam int NG  = 2;
  localparam int EW  = 3;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    rmsg;
  logic          rxv;
  logic          busy;
  logic          vrx;
  logic [NG-1:0] grp;
  logic [3:0]    o_msg;
  logic          o_vtx;
  logic [EW-1:0] o_enc;
  logic          o_ack;
  logic          o_err;
  logic          o_tmo;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 idle, 1..3 = n-th request outstanding, 4 done, 5 error
  int m_phase, m_age;
  int m_msg, m_enc;
  bit m_vtx, m_ack, m_err, m_tmo;

  repair_tx_gen #(.NUM_GROUPS(NG), .ENC_W(EW), .TIMEOUT_CYC(TMO)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .i_en                           (en),
    .i_sideband_message             (rmsg),
    .i_rx_msg_valid                 (rxv),
    .i_busy_negedge_detected        (busy),
    .i_valid_rx                     (vrx),
    .i_group_functional             (grp),
    .o_sideband_message             (o_msg),
    .o_valid_tx                     (o_vtx),
    .o_sideband_data_lanes_encoding (o_enc),
    .o_test_ack                     (o_ack),
    .o_error                        (o_err),
    .o_timeout                      (o_tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_msg = 0; m_enc = 0;
    m_vtx = 0; m_ack = 0; m_err = 0; m_tmo = 0;
  endtask

  task automatic model_clear_outputs();
    m_msg = 0; m_enc = 0; m_vtx = 0; m_ack = 0; m_err = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    bit got;
    if (m_phase == 0) begin
      model_clear_outputs();
      if (en) begin
        m_phase = 1; m_age = 0; m_msg = 1; m_vtx = 1;
      end
    end else if (!en) begin
      m_phase = 0; m_age = 0;
      model_clear_outputs();
    end else if (m_phase <= 3) begin
      got = rxv && (int'(rmsg) == 2 * m_phase);
      if (got && m_phase == 1 && grp == 0) begin
        m_phase = 5; m_msg = 0; m_vtx = 0; m_err = 1; m_tmo = 0;
      end else if (got && m_phase == 3) begin
        m_phase = 4; m_msg = 0; m_vtx = 0; m_ack = 1;
      end else if (got) begin
        if (m_phase == 1) m_enc = int'(grp);
        m_phase++;
        m_msg = 2 * m_phase - 1; m_vtx = 1; m_age = 0;
      end else if (m_age == TMO - 1) begin
        m_phase = 5; m_msg = 0; m_vtx = 0; m_err = 1; m_tmo = 1;
      end else begin
        m_age++;
        if (busy && !vrx) m_vtx = 0;
      end
    end
  endtask

  always @(posedge clk) if (rst_n) model_step();

  task automatic compare_all(input string tag);
    chk({tag, ".msg"}, 32'(o_msg), 32'(m_msg));
    chk({tag, ".vtx"}, 32'(o_vtx), 32'(m_vtx));
    chk({tag, ".enc"}, 32'(o_enc), 32'(m_enc));
    chk({tag, ".ack"}, 32'(o_ack), 32'(m_ack));
    chk({tag, ".err"}, 32'(o_err), 32'(m_err));
    chk({tag, ".tmo"}, 32'(o_tmo), 32'(m_tmo));
  endtask

  task automatic cyc(input string tag, input logic e, input logic rv, input logic [3:0] m,
                     input logic b, input logic v, input logic [NG-1:0] g);
    en = e; rxv = rv; rmsg = m; busy = b; vrx = v; grp = g;
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; rmsg = 4'd0; rxv = 1'b0; busy = 1'b0; vrx = 1'b0; grp = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare_all("reset");
    chk("reset.msg_zero", 32'(o_msg), 32'd0);

    // 1: normal sequence, all groups functional
    cyc("t1.init", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    chk("t1.init_req", 32'(o_msg), 32'd1);
    cyc("t1.busy", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 2'b11);
    cyc("t1.irsp", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b11);
    chk("t1.deg_req", 32'(o_msg), 32'd3);
    chk("t1.enc", 32'(o_enc), 32'd3);
    cyc("t1.drsp", 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 2'b11);
    chk("t1.end_req", 32'(o_msg), 32'd5);
    cyc("t1.ersp", 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 2'b11);
    chk("t1.ack", 32'(o_ack), 32'd1);
    cyc("t1.hold", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    idle("t1.off");

    // 2: degraded mask, then no functional groups
    cyc("t2.init", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10);
    cyc("t2.irsp", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b10);
    chk("t2.enc", 32'(o_enc), 32'd2);
    cyc("t2.drsp", 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 2'b01);
    cyc("t2.ersp", 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 2'b01);
    chk("t2.enc_hold", 32'(o_enc), 32'd2);
    idle("t2.off");
    cyc("t2.init0", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
    cyc("t2.nolane", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b00);
    chk("t2.err", 32'(o_err), 32'd1);
    chk("t2.tmo", 32'(o_tmo), 32'd0);
    chk("t2.vtx", 32'(o_vtx), 32'd0);
    idle("t2.off2");

    // 3: timeout in DEGRADE lands exactly TMO cycles after entry
    cyc("t3.init", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    cyc("t3.irsp", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b11);
    for (int k = 1; k <= TMO; k++) begin
      cyc("t3.wait", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
      if (k == TMO - 1) chk("t3.not_yet", 32'(o_err), 32'd0);
      if (k == TMO) begin
        chk("t3.err", 32'(o_err), 32'd1);
        chk("t3.tmo", 32'(o_tmo), 32'd1);
      end
    end
    idle("t3.off");
    chk("t3.off_err", 32'(o_err), 32'd0);

    // 4: unqualified and out-of-order responses are ignored
    cyc("t4.init", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    cyc("t4.ooo", 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 2'b11);
    chk("t4.still_init", 32'(o_msg), 32'd1);
    cyc("t4.irsp", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b11);
    cyc("t4.novalid", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 2'b11);
    chk("t4.still_deg", 32'(o_msg), 32'd3);
    idle("t4.off");

    // 5: valid_tx handshake
    cyc("t5.init", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    cyc("t5.rxbusy", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 2'b11);
    chk("t5.keep", 32'(o_vtx), 32'd1);
    cyc("t5.clear", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 2'b11);
    chk("t5.cleared", 32'(o_vtx), 32'd0);
    cyc("t5.setwin", 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 2'b11);
    chk("t5.setwin", 32'(o_vtx), 32'd1);
    idle("t5.off");

    // 6: abort mid-END, async reset mid-DEGRADE, re-enable
    cyc("t6.init", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    cyc("t6.irsp", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b11);
    cyc("t6.drsp", 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 2'b11);
    idle("t6.abort");
    chk("t6.abort_msg", 32'(o_msg), 32'd0);
    cyc("t6.reinit", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    chk("t6.reinit_req", 32'(o_msg), 32'd1);
    cyc("t6.irsp2", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b11);
    #2 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    compare_all("t6.rst");
    chk("t6.rst_enc", 32'(o_enc), 32'd0);
    cyc("t6.after_rst", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
    chk("t6.reissue", 32'(o_msg), 32'd1);

    // random traffic, responses biased toward the one the model expects
    for (int n = 0; n < 3000; n++) begin
      logic          r_en, r_rv, r_b, r_v;
      logic [3:0]    r_m;
      logic [NG-1:0] r_g;
      r_en = (m_phase >= 4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) != 0);
      r_rv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && m_phase >= 1 && m_phase <= 3) r_m = 4'(2 * m_phase);
      else r_m = 4'($urandom_range(0, 7));
      r_g = NG'($urandom_range(0, 3));
      r_b = 1'($urandom_range(0, 1));
      r_v = 1'($urandom_range(0, 1));
      cyc("rnd", r_en, r_rv, r_m, r_b, r_v, r_g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
